layer_stream_ctrl: RTL and testbench

Sequencer between a fully parallel neuron layer and the next layer's serial input. It captures the layer's NN parallel outputs when every neuron reports valid, then replays them one word per transfer on a serial `x_valid`/`x_in` stream. That stream drives the next layer's shared neuron input. It also detects partial-valid and overrun events and counts completed frames.

---
 rtl/layer_stream_ctrl.sv | 132 +++++++++++++
 tb/tb_layer_stream_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_stream_ctrl.sv
// layer_stream_ctrl: captures a fully parallel neuron layer's outputs once
// every neuron reports valid, then replays them one word per transfer on a
// serial x_valid/x_in stream for the next layer. Flags partial-valid and
// overrun events (sticky) and counts completed frames.
module layer_stream_ctrl #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           o_valid,
    input  logic [NN*dataWidth-1:0] x_out,
    input  logic                    ready,
    output logic                    x_valid,
    output logic [dataWidth-1:0]    x_in,
    output logic                    last,
    output logic                    busy,
    output logic                    err_partial,
    output logic                    err_overrun,
    output logic [15:0]             frame_cnt
);
    localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NN - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [IDX_W-1:0]       r_idx;
    logic [dataWidth-1:0]   r_buf [NN];
    logic                   r_x_valid;
    logic [dataWidth-1:0]   r_x_in;
    logic                   r_last;
    logic                   r_err_partial;
    logic                   r_err_overrun;
    logic [15:0]            r_frame_cnt;

    logic w_full;
    logic w_partial;
    logic w_issue;
    logic w_final;
    logic w_capture;
    logic w_overrun;

    assign w_full    = &o_valid;
    assign w_partial = (|o_valid) && !w_full;
    assign w_issue   = (r_state == S_STREAM) && ready;
    assign w_final   = w_issue && (r_idx == IDX_LAST);
    // A new frame is accepted in IDLE, or on the edge that drains the last
    // word so back-to-back frames stream with no idle cycle between them.
    assign w_capture = w_full && ((r_state == S_IDLE) || w_final);
    assign w_overrun = w_full && (r_state == S_STREAM) && !w_final;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic: leave STREAM only when the final word goes out
    // without a new frame arriving on the same edge
    always_comb begin
        w_next = r_state;
        if (r_state == S_IDLE) begin
            if (w_full) w_next = S_STREAM;
        end else begin
            if (w_final && !w_full) w_next = S_IDLE;
        end
    end

    // Output decode from state
    always_comb begin
        busy = (r_state == S_STREAM);
    end

    // Capture buffer: loaded only when a frame is accepted; overrun data is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NN; i++) r_buf[i] <= '0;
        end else if (w_capture) begin
            for (int i = 0; i < NN; i++) r_buf[i] <= x_out[i*dataWidth +: dataWidth];
        end
    end

    // Index counter: restarts on capture, advances on each non-final issue
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_capture) begin
            r_idx <= '0;
        end else if (w_issue && !w_final) begin
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    // Serial output stage: x_in holds its value between issued words
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_valid   <= 1'b0;
            r_x_in      <= '0;
            r_last      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_x_valid <= w_issue;
            r_last    <= w_final;
            if (w_issue) r_x_in <= r_buf[r_idx];
            if (w_final) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_partial <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            if (w_partial) r_err_partial <= 1'b1;
            if (w_overrun) r_err_overrun <= 1'b1;
        end
    end

    assign x_valid     = r_x_valid;
    assign x_in        = r_x_in;
    assign last        = r_last;
    assign err_partial = r_err_partial;
    assign err_overrun = r_err_overrun;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_layer_stream_ctrl.sv
// Testbench for layer_stream_ctrl: directed scenarios plus a randomized run,
// all checked cycle by cycle against a queue-based reference model.
module tb_layer_stream_ctrl;
    localparam int NN = 30;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NN-1:0]     o_valid = '0;
    logic [NN*DW-1:0]  x_out = '0;
    logic              ready = 1'b0;
    logic              x_valid;
    logic [DW-1:0]     x_in;
    logic              last;
    logic              busy;
    logic              err_partial;
    logic              err_overrun;
    logic [15:0]       frame_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    layer_stream_ctrl #(.NN(NN), .dataWidth(DW)) dut (
        .clk(clk), .rst(rst), .o_valid(o_valid), .x_out(x_out), .ready(ready),
        .x_valid(x_valid), .x_in(x_in), .last(last), .busy(busy),
        .err_partial(err_partial), .err_overrun(err_overrun), .frame_cnt(frame_cnt)
    );

    // Reference model: words still owed for the current frame live in a queue;
    // the controller is busy exactly while that queue is non-empty.
    logic [DW-1:0] m_q [$];
    logic          m_xv = 1'b0;
    logic [DW-1:0] m_xin = '0;
    logic          m_last = 1'b0;
    logic          m_ep = 1'b0;
    logic          m_eo = 1'b0;
    logic [15:0]   m_fc = '0;

    wire [36:0] obs = {x_valid, x_in, last, busy, err_partial, err_overrun, frame_cnt};

    function automatic logic [36:0] exp_v();
        logic mb;
        mb = (m_q.size() != 0);
        return {m_xv, m_xin, m_last, mb, m_ep, m_eo, m_fc};
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_q.delete();
            m_xv = 0; m_xin = '0; m_last = 0; m_ep = 0; m_eo = 0; m_fc = '0;
        end else begin
            m_xv = 0; m_last = 0;
            if (m_q.size() != 0 && ready) begin
                m_xin = m_q.pop_front();
                m_xv  = 1;
                if (m_q.size() == 0) begin
                    m_last = 1;
                    m_fc   = m_fc + 16'd1;
                end
            end
            if (&o_valid) begin
                if (m_q.size() == 0) begin
                    for (int i = 0; i < NN; i++) m_q.push_back(x_out[i*DW +: DW]);
                end else begin
                    m_eo = 1;
                end
            end else if (o_valid != '0) begin
                m_ep = 1;
            end
        end
    endtask

    // One clock: inputs were set at the preceding negedge; outputs are read at the next one.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic load_x(input logic [15:0] base, input bit inc);
        for (int i = 0; i < NN; i++) x_out[i*DW +: DW] = inc ? base + 16'(i) : base;
    endtask

    task automatic do_rst();
        o_valid = '0; ready = 0; rst = 1;
        step(); step();
        rst = 0;
    endtask

    task automatic test_reset();
        do_rst();
        n_chk++;
        if (obs !== 37'd0) begin
            n_fail++; $display("FAIL reset_state got %h want %h", obs, 37'd0);
        end
        step();
        n_chk++;
        if (obs !== exp_v()) begin
            n_fail++; $display("FAIL reset_idle got %h want %h", obs, exp_v());
        end
    endtask

    task automatic test_single_frame();
        int first = -1;
        int nb = 0;
        int nl = 0;
        logic [DW-1:0] lw = '0;
        logic [DW-1:0] got [$];
        do_rst();
        ready = 1; load_x(16'h0100, 1); o_valid = '1;
        for (int c = 1; c <= 36; c++) begin
            step();
            o_valid = '0;
            n_chk++;
            if (obs !== exp_v()) begin
                n_fail++; $display("FAIL single_cyc%0d got %h want %h", c, obs, exp_v());
            end
            if (x_valid) begin
                if (first < 0) first = c;
                got.push_back(x_in);
            end
            if (last) begin nl++; lw = x_in; end
            if (busy) nb++;
        end
        n_chk++;
        if (first !== 2) begin n_fail++; $display("FAIL single_latency got %0d want 2", first); end
        n_chk++;
        if (got.size() !== NN) begin n_fail++; $display("FAIL single_count got %0d want %0d", got.size(), NN); end
        for (int i = 0; i < got.size(); i++) begin
            n_chk++;
            if (got[i] !== 16'h0100 + 16'(i)) begin
                n_fail++; $display("FAIL single_word%0d got %h want %h", i, got[i], 16'h0100 + 16'(i));
            end
        end
        n_chk++;
        if (nl !== 1 || lw !== 16'h011D) begin n_fail++; $display("FAIL single_last got %0d/%h want 1/011d", nl, lw); end
        n_chk++;
        if (nb !== NN) begin n_fail++; $display("FAIL single_busy got %0d want %0d", nb, NN); end
        n_chk++;
        if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL single_fcnt got %0d want 1", frame_cnt); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] got [$];
        logic rprev;
        do_rst();
        load_x(16'h0100, 1); o_valid = '1; ready = 1;
        for (int c = 1; c <= 70; c++) begin
            rprev = ready;
            step();
            o_valid = '0;
            n_chk++;
            if (obs !== exp_v()) begin
                n_fail++; $display("FAIL bp_cyc%0d got %h want %h", c, obs, exp_v());
            end
            n_chk++;
            if (x_valid && !rprev) begin n_fail++; $display("FAIL bp_gap_cyc%0d got x_valid 1 want 0", c); end
            if (x_valid) got.push_back(x_in);
            ready = ~ready;
        end
        n_chk++;
        if (got.size() !== NN) begin n_fail++; $display("FAIL bp_count got %0d want %0d", got.size(), NN); end
        for (int i = 0; i < got.size(); i++) begin
            n_chk++;
            if (got[i] !== 16'h0100 + 16'(i)) begin
                n_fail++; $display("FAIL bp_word%0d got %h want %h", i, got[i], 16'h0100 + 16'(i));
            end
        end
        n_chk++;
        if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL bp_fcnt got %0d want 1", frame_cnt); end
    endtask

    task automatic test_overrun();
        logic [DW-1:0] got [$];
        do_rst();
        ready = 1; load_x(16'h0100, 1); o_valid = '1;
        for (int c = 1; c <= 36; c++) begin
            step();
            o_valid = '0;
            // word 10 is issued on edge 12; the second pulse lands there
            if (c == 11) begin load_x(16'hAAAA, 0); o_valid = '1; end
            n_chk++;
            if (obs !== exp_v()) begin
                n_fail++; $display("FAIL ovr_cyc%0d got %h want %h", c, obs, exp_v());
            end
            if (x_valid) got.push_back(x_in);
        end
        n_chk++;
        if (err_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got %b want 1", err_overrun); end
        n_chk++;
        if (got.size() !== NN) begin n_fail++; $display("FAIL ovr_count got %0d want %0d", got.size(), NN); end
        for (int i = 0; i < got.size(); i++) begin
            n_chk++;
            if (got[i] !== 16'h0100 + 16'(i)) begin
                n_fail++; $display("FAIL ovr_word%0d got %h want %h", i, got[i], 16'h0100 + 16'(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] got [$];
        int nv = 0;
        do_rst();
        ready = 1; load_x(16'h0100, 1); o_valid = '1;
        for (int c = 1; c <= 66; c++) begin
            step();
            o_valid = '0;
            // word 29 is issued on edge 31
            if (c == 30) begin load_x(16'h0200, 1); o_valid = '1; end
            n_chk++;
            if (obs !== exp_v()) begin
                n_fail++; $display("FAIL b2b_cyc%0d got %h want %h", c, obs, exp_v());
            end
            if (c >= 2 && c <= 61) begin
                n_chk++;
                if (x_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_gap_cyc%0d got %b want 1", c, x_valid); end
            end
            if (x_valid) begin got.push_back(x_in); nv++; end
        end
        n_chk++;
        if (got.size() !== 2*NN) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", got.size(), 2*NN); end
        for (int i = 0; i < got.size() && i < 2*NN; i++) begin
            n_chk++;
            if (got[i] !== ((i < NN) ? 16'h0100 + 16'(i) : 16'h0200 + 16'(i - NN))) begin
                n_fail++; $display("FAIL b2b_word%0d got %h", i, got[i]);
            end
        end
        n_chk++;
        if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got %b want 0", err_overrun); end
        n_chk++;
        if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL b2b_fcnt got %0d want 2", frame_cnt); end
    endtask

    task automatic test_partial();
        int nv = 0;
        int nb = 0;
        do_rst();
        ready = 1; load_x(16'h0100, 1); o_valid = 30'h0000_0001;
        for (int c = 1; c <= 5; c++) begin
            step();
            o_valid = '0;
            n_chk++;
            if (obs !== exp_v()) begin
                n_fail++; $display("FAIL part_cyc%0d got %h want %h", c, obs, exp_v());
            end
            if (x_valid) nv++;
            if (busy) nb++;
        end
        n_chk++;
        if (err_partial !== 1'b1 || nv !== 0 || nb !== 0) begin
            n_fail++; $display("FAIL part_result got ep=%b xv=%0d busy=%0d want 1/0/0", err_partial, nv, nb);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] got [$];
        do_rst();
        ready = 1; o_valid = 30'h0000_0100;
        step();
        load_x(16'h0100, 1); o_valid = '1;
        for (int c = 1; c <= 17; c++) begin
            step();
            o_valid = '0;
        end
        // word 15 is visible now; reset on the next edge
        rst = 1;
        step();
        rst = 0;
        n_chk++;
        if (obs !== 37'd0) begin n_fail++; $display("FAIL rstmid_state got %h want %h", obs, 37'd0); end
        for (int c = 1; c <= 4; c++) begin
            step();
            n_chk++;
            if (x_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL rstmid_quiet_cyc%0d got xv=%b busy=%b want 0/0", c, x_valid, busy);
            end
        end
        load_x(16'h0300, 1); o_valid = '1;
        for (int c = 1; c <= 34; c++) begin
            step();
            o_valid = '0;
            n_chk++;
            if (obs !== exp_v()) begin
                n_fail++; $display("FAIL rstmid_cyc%0d got %h want %h", c, obs, exp_v());
            end
            if (x_valid) got.push_back(x_in);
        end
        n_chk++;
        if (got.size() !== NN || got[0] !== 16'h0300 || got[NN-1] !== 16'h031D) begin
            n_fail++; $display("FAIL rstmid_restream got n=%0d", got.size());
        end
    endtask

    task automatic test_random();
        int r;
        logic [NN-1:0] pv;
        do_rst();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NN; i++) x_out[i*DW +: DW] = 16'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                o_valid = '1;
            end else if (r < 6) begin
                pv = NN'($urandom);
                if (pv == '0 || pv == '1) pv = NN'(1);
                o_valid = pv;
            end else begin
                o_valid = '0;
            end
            rst = ($urandom_range(0, 399) == 0);
            step();
            n_chk++;
            if (obs !== exp_v()) begin
                n_fail++; $display("FAIL rand_cyc%0d got %h want %h", c, obs, exp_v());
            end
        end
        rst = 0; o_valid = '0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_backpressure();
        test_overrun();
        test_back_to_back();
        test_partial();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
